// File: rtl/bit_serial_adder.sv
// Bit-serial adder: parallel operands are summed LSB-first through one full-adder
// cell and a carry flop, with results returned on a valid/ready handshake.
module bit_serial_adder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
  logic [CNT_W-1:0]   cnt;
  logic               c, c_msb;
  logic               prop, gen1, gen2, s_bit, c_nxt;

  // Full-adder cell built from two half adders and an OR.
  always_comb begin
    prop  = a_sh[0] ^ b_sh[0];
    gen1  = a_sh[0] & b_sh[0];
    s_bit = prop ^ c;
    gen2  = prop & c;
    c_nxt = gen1 | gen2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    sum       = '0;
    cout      = 1'b0;
    ovf       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        sum       = sum_sh;
        cout      = c;
        ovf       = c_msb ^ c;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      c_msb  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            c    <= cin;
            cnt  <= '0;
          end
        end
        RUN: begin
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          c      <= c_nxt;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          // Carry produced by bit WIDTH-2 is the carry into the MSB.
          if (cnt == CNT_W'(WIDTH - 2)) c_msb <= c_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH=64 and WIDTH=2.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, cin, out_ready;
  logic [63:0] a, b, sum;
  logic        in_ready, busy, cout, ovf, out_valid;

  logic        start2, cin2, out_ready2;
  logic [1:0]  a2, b2, sum2;
  logic        in_ready2, busy2, cout2, ovf2, out_valid2;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q64[$];
  exp_t q2[$];
  exp_t e64, e2;

  bit_serial_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .in_ready(in_ready), .busy(busy), .sum(sum), .cout(cout), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  bit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .in_ready(in_ready2), .busy(busy2), .sum(sum2), .cout(cout2), .ovf(ovf2),
    .out_valid(out_valid2), .out_ready(out_ready2)
  );

  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y,
                                 input logic ci, input int w);
    logic [64:0] t;
    logic [63:0] mask;
    exp_t        e;
    mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    t      = {1'b0, x & mask} + {1'b0, y & mask} + {64'd0, ci};
    e.sum  = t[63:0] & mask;
    e.cout = t[w];
    e.ovf  = (x[w-1] == y[w-1]) && (e.sum[w-1] != x[w-1]);
    return e;
  endfunction

  // Scoreboard monitors: a result is consumed on the edge after valid&ready is seen.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (q64.size() == 0) begin
        n_miss++;
        $display("FAIL out64_unexpected: got sum=%h cout=%b ovf=%b, required no output", sum, cout, ovf);
      end else begin
        e64 = q64.pop_front();
        if ({sum, cout, ovf} !== {e64.sum, e64.cout, e64.ovf}) begin
          n_miss++;
          $display("FAIL out64: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   sum, cout, ovf, e64.sum, e64.cout, e64.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid2 && out_ready2) begin
      n_vec++;
      if (q2.size() == 0) begin
        n_miss++;
        $display("FAIL out2_unexpected: got sum=%b cout=%b ovf=%b, required no output", sum2, cout2, ovf2);
      end else begin
        e2 = q2.pop_front();
        if ({sum2, cout2, ovf2} !== {e2.sum[1:0], e2.cout, e2.ovf}) begin
          n_miss++;
          $display("FAIL out2: got sum=%b cout=%b ovf=%b, required sum=%b cout=%b ovf=%b",
                   sum2, cout2, ovf2, e2.sum[1:0], e2.cout, e2.ovf);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue64(input logic [63:0] x, input logic [63:0] y, input logic ci);
    int n = 0;
    while (!in_ready && n < 500) begin step(); n++; end
    a = x; b = y; cin = ci; start = 1'b1;
    q64.push_back(model(x, y, ci, 64));
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid64(output int n);
    n = 0;
    while (!out_valid && n < 500) begin step(); n++; end
  endtask

  task automatic run_op64(input logic [63:0] x, input logic [63:0] y, input logic ci);
    int n;
    issue64(x, y, ci);
    wait_valid64(n);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_op2(input logic [1:0] x, input logic [1:0] y, input logic ci);
    int n = 0;
    while (!in_ready2 && n < 50) begin step(); n++; end
    a2 = x; b2 = y; cin2 = ci; start2 = 1'b1;
    q2.push_back(model({62'd0, x}, {62'd0, y}, ci, 2));
    step();
    start2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 50) begin step(); n++; end
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b0;
    #3;
    n_vec++;
    if ({in_ready, busy, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL reset_outputs: got in_ready=%b busy=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 0 0 0 0",
               in_ready, busy, out_valid, sum, cout, ovf);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    n_vec++;
    if ({in_ready, busy, out_valid, in_ready2} !== 4'b1001) begin
      n_miss++;
      $display("FAIL reset_idle: got in_ready=%b busy=%b out_valid=%b in_ready2=%b, required 1 0 0 1",
               in_ready, busy, out_valid, in_ready2);
    end
  endtask

  task automatic test_latency;
    int n = 0;
    issue64(64'd0, 64'd0, 1'b0);
    while (busy && n < 500) begin step(); n++; end
    n_vec++;
    if (n !== 64) begin
      n_miss++;
      $display("FAIL busy_cycles: got %0d, required 64", n);
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_miss++;
      $display("FAIL valid_latency: got out_valid=%b after 64 cycles, required 1", out_valid);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL ready_after_ack: got in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_arith;
    run_op64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run_op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run_op64(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    run_op64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
  endtask

  task automatic test_handshake;
    int n;
    issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    repeat (5) step();
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h5555_5555_5555_5555; cin = 1'b1;
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    n_vec++;
    if ({busy, in_ready, out_valid} !== 3'b100) begin
      n_miss++;
      $display("FAIL ignore_in_run: got busy=%b in_ready=%b out_valid=%b, required 1 0 0", busy, in_ready, out_valid);
    end
    wait_valid64(n);
    n_vec++;
    if (n >= 500) begin
      n_miss++;
      $display("FAIL hs_timeout: got no out_valid in %0d cycles, required out_valid", n);
    end
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({out_valid, sum, cout, ovf} !== {1'b1, 64'd0, 1'b1, 1'b0}) begin
        n_miss++;
        $display("FAIL hold_stable[%0d]: got valid=%b sum=%h cout=%b ovf=%b, required 1 0 1 0",
                 i, out_valid, sum, cout, ovf);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_miss++;
      $display("FAIL release_ready: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    run_op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    run_op64(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
  endtask

  task automatic test_reset_mid;
    issue64(64'hDEAD_BEEF_0000_FFFF, 64'h0F0F_0F0F_F0F0_F0F0, 1'b1);
    repeat (29) step();
    n_vec++;
    if (busy !== 1'b1) begin
      n_miss++;
      $display("FAIL mid_busy: got busy=%b, required 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, busy, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0}) begin
      n_miss++;
      $display("FAIL async_reset: got in_ready=%b busy=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 0 0 0 0",
               in_ready, busy, out_valid, sum, cout, ovf);
    end
    void'(q64.pop_back());
    step();
    rst_n = 1'b1;
    step();
    run_op64(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    n_vec++;
    if (q64.size() !== 0) begin
      n_miss++;
      $display("FAIL post_reset_drain: got %0d pending, required 0", q64.size());
    end
  endtask

  task automatic test_random;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          run_op64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      end
      begin
        for (int j = 0; j < 1000; j++)
          run_op2(2'($urandom), 2'($urandom), 1'($urandom));
      end
    join
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_handshake();
    test_reset_mid();
    test_random();
    n_vec++;
    if (q64.size() !== 0 || q2.size() !== 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", q64.size(), q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
